// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - decode-side bundle between the pipeline and the hazard/forward unit
interface hazard_fwd_unit_if #(
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             flush;
    logic [SEL_W-1:0] fwd_sel_a;
    logic [SEL_W-1:0] fwd_sel_b;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_instr, id_valid, flush,
        input  fwd_sel_a, fwd_sel_b, stall, stall_count
    );

    modport slave (
        input  id_instr, id_valid, flush,
        output fwd_sel_a, fwd_sel_b, stall, stall_count
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - destination scoreboard driving EX forward selects and load-use stall
module hazard_fwd_unit #(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_fwd_unit_if.slave bus
);
    generate
        if (DEPTH < 1 || LOAD_STAGE < 1 || LOAD_STAGE > DEPTH || (2 ** SEL_W) <= DEPTH) begin : g_bad_params
            $error("hazard_fwd_unit: illegal DEPTH/LOAD_STAGE/SEL_W combination");
        end
    endgenerate

    logic [5:0]       op;
    logic [5:0]       func;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             unused_shamt;

    assign op           = bus.id_instr[31:26];
    assign func         = bus.id_instr[5:0];
    assign rs           = REG_W'(bus.id_instr[25:21]);
    assign rt           = REG_W'(bus.id_instr[20:16]);
    assign rd           = REG_W'(bus.id_instr[15:11]);
    assign unused_shamt = ^bus.id_instr[10:6];

    logic             wr;
    logic [REG_W-1:0] wdst;
    logic             use_rs;
    logic             use_rt;
    logic             is_ld;

    always_comb begin
        wr     = 1'b0;
        wdst   = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        is_ld  = 1'b0;
        case (op)
            6'h00: begin
                case (func)
                    6'h23, 6'h27, 6'h2B: begin
                        wr     = 1'b1;
                        wdst   = rd;
                        use_rs = 1'b1;
                        use_rt = 1'b1;
                    end
                    6'h08:   use_rs = 1'b1;
                    default: ;
                endcase
            end
            6'h08: begin
                wr     = 1'b1;
                wdst   = rt;
                use_rs = 1'b1;
            end
            6'h23: begin
                wr     = 1'b1;
                wdst   = rt;
                use_rs = 1'b1;
                is_ld  = 1'b1;
            end
            6'h2B: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            6'h01:   use_rs = 1'b1;
            default: ;
        endcase
        // $0 is hardwired, so a write to it must never be forwarded
        if (wdst == '0) begin
            wr = 1'b0;
        end
    end

    // index 0 is stage 1 (EX); index DEPTH-1 is the last forwardable stage
    logic [REG_W-1:0] dst_q [DEPTH];
    logic             vld_q [DEPTH];
    logic             ld_q  [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             haz_a;
    logic             haz_b;
    logic             stall;
    logic             ent_en;

    // scan oldest to youngest so the youngest match is the one left standing
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_rs && vld_q[k] && dst_q[k] == rs) begin
                sel_a = SEL_W'(k + 1);
                haz_a = haz_a | (ld_q[k] && (k + 1 < LOAD_STAGE));
            end
            if (use_rt && vld_q[k] && dst_q[k] == rt) begin
                sel_b = SEL_W'(k + 1);
                haz_b = haz_b | (ld_q[k] && (k + 1 < LOAD_STAGE));
            end
        end
    end

    assign stall  = bus.id_valid && !bus.flush && (haz_a || haz_b);
    assign ent_en = bus.id_valid && !stall && !bus.flush && wr;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= '0;
                vld_q[k] <= 1'b0;
                ld_q[k]  <= 1'b0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                dst_q[k] <= dst_q[k-1];
                vld_q[k] <= vld_q[k-1];
                ld_q[k]  <= ld_q[k-1];
            end
            dst_q[0] <= wdst;
            vld_q[0] <= ent_en;
            ld_q[0]  <= ent_en && is_ld;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.fwd_sel_a   = sel_a;
    assign bus.fwd_sel_b   = sel_b;
    assign bus.stall       = stall;
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed scoreboard bench for hazard_fwd_unit (default and deep configs)
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.SEL_W(2), .CNT_W(16)) if0 ();
    hazard_fwd_unit_if #(.SEL_W(2), .CNT_W(2))  if1 ();

    hazard_fwd_unit #(.REG_W(5), .DEPTH(2), .LOAD_STAGE(2), .SEL_W(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    hazard_fwd_unit #(.REG_W(5), .DEPTH(3), .LOAD_STAGE(3), .SEL_W(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic        s;
        logic [15:0] c;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt0   = 0;
    int   cnt1   = 0;

    function automatic logic [31:0] f_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {6'h08, rs, rt, imm};
    endfunction
    function automatic logic [31:0] f_lw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'h23, rs, rt, 16'h0000};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rt, input logic [4:0] rs);
        return {6'h2B, rs, rt, 16'h0000};
    endfunction
    function automatic logic [31:0] f_bltz(input logic [4:0] rs);
        return {6'h01, rs, 5'd0, 16'h0010};
    endfunction
    function automatic logic [31:0] f_r(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop0(input string tag);
        exp_t e;
        if (sb0.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb0.pop_front();
            chk({tag, ".sel_a"}, 16'(if0.fwd_sel_a), 16'(e.a));
            chk({tag, ".sel_b"}, 16'(if0.fwd_sel_b), 16'(e.b));
            chk({tag, ".stall"}, 16'(if0.stall), 16'(e.s));
            chk({tag, ".count"}, if0.stall_count, e.c);
        end
    endtask

    task automatic pop1(input string tag);
        exp_t e;
        if (sb1.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb1.pop_front();
            chk({tag, ".sel_a"}, 16'(if1.fwd_sel_a), 16'(e.a));
            chk({tag, ".sel_b"}, 16'(if1.fwd_sel_b), 16'(e.b));
            chk({tag, ".stall"}, 16'(if1.stall), 16'(e.s));
            chk({tag, ".count"}, 16'(if1.stall_count), e.c);
        end
    endtask

    task automatic step0(input string tag, input logic [31:0] ins, input logic v, input logic f,
                         input logic [1:0] a, input logic [1:0] b, input logic s);
        @(negedge clk);
        if0.id_instr = ins;
        if0.id_valid = v;
        if0.flush    = f;
        sb0.push_back('{a, b, s, 16'(cnt0)});
        #2;
        pop0(tag);
        if (s) cnt0++;
    endtask

    task automatic step1(input string tag, input logic [31:0] ins,
                         input logic [1:0] a, input logic [1:0] b, input logic s);
        @(negedge clk);
        if1.id_instr = ins;
        if1.id_valid = 1'b1;
        if1.flush    = 1'b0;
        sb1.push_back('{a, b, s, 16'(cnt1)});
        #2;
        pop1(tag);
        if (s && cnt1 < 3) cnt1++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        if0.id_instr = '0; if0.id_valid = 1'b0; if0.flush = 1'b0;
        if1.id_instr = '0; if1.id_valid = 1'b0; if1.flush = 1'b0;
        #12;
        sb0.push_back('{2'd0, 2'd0, 1'b0, 16'd0});
        pop0("reset");
        sb1.push_back('{2'd0, 2'd0, 1'b0, 16'd0});
        pop1("reset1");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back and one-gap forwarding
        step0("addi5",   f_addi(5, 0, 1), 1, 0, 0, 0, 0);
        step0("subu_fw1", f_r(6'h23, 6, 5, 5), 1, 0, 1, 1, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("addi5b",  f_addi(5, 0, 1), 1, 0, 0, 0, 0);
        step0("nop",     '0, 1, 0, 0, 0, 0);
        step0("subu_fw2", f_r(6'h23, 6, 5, 5), 1, 0, 2, 2, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);

        // load-use: one stall then forward from stage 2
        step0("lw8",     f_lw(8, 1), 1, 0, 0, 0, 0);
        step0("use_stall", f_addi(9, 8, 4), 1, 0, 1, 0, 1);
        step0("use_fw2", f_addi(9, 8, 4), 1, 0, 2, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);

        // youngest match wins; $0 never forwards
        step0("addi3a",  f_addi(3, 0, 1), 1, 0, 0, 0, 0);
        step0("addi3b",  f_addi(3, 3, 1), 1, 0, 1, 0, 0);
        step0("subu_young", f_r(6'h23, 4, 3, 0), 1, 0, 1, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);

        // sw uses both sources, bltz only rs
        step0("nor7",    f_r(6'h27, 7, 1, 2), 1, 0, 0, 0, 0);
        step0("sw7",     f_sw(7, 7), 1, 0, 1, 1, 0);
        step0("nor7b",   f_r(6'h27, 7, 1, 2), 1, 0, 0, 0, 0);
        step0("bltz7",   f_bltz(7), 1, 0, 1, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);

        // flush masks the hazard and injects a bubble
        step0("lw8f",    f_lw(8, 1), 1, 0, 0, 0, 0);
        step0("use_flush", f_addi(9, 8, 4), 1, 1, 1, 0, 0);
        step0("after_flush", f_addi(9, 8, 4), 1, 0, 2, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);
        step0("idle",    '0, 0, 0, 0, 0, 0);

        // asynchronous reset while stalled
        step0("lw8r",    f_lw(8, 1), 1, 0, 0, 0, 0);
        step0("use_pre_rst", f_addi(9, 8, 4), 1, 0, 1, 0, 1);
        rst_n = 1'b0;
        #1;
        cnt0 = 0;
        sb0.push_back('{2'd0, 2'd0, 1'b0, 16'd0});
        pop0("rst_mid_stall");
        @(posedge clk);
        #1 rst_n = 1'b1;
        if0.id_instr = '0; if0.id_valid = 1'b0; if0.flush = 1'b0;

        // deep config: two stalls per load-use pair, 2-bit counter saturates
        for (int p = 0; p < 6; p++) begin
            step1("d_lw",   f_lw(8, 1), 0, 0, 0);
            step1("d_use1", f_addi(9, 8, 4), 1, 0, 1);
            step1("d_use2", f_addi(9, 8, 4), 2, 0, 1);
            step1("d_use3", f_addi(9, 8, 4), 3, 0, 0);
        end
        @(negedge clk);
        #2;
        chk("d_sat", 16'(if1.stall_count), 16'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
